// File: rtl/ssd1306_pkg.sv
// Shared opcodes, FSM states and frame sizes for the SSD1306 frame sequencer.
// Contents: command opcodes, seq_state_e, FRAME_BYTES/CMD_BYTES, cmd_rom().
package ssd1306_pkg;

   localparam logic [7:0] OP_MEMORYMODE = 8'h20;
   localparam logic [7:0] OP_COLUMNADDR = 8'h21;
   localparam logic [7:0] OP_PAGEADDR   = 8'h22;
   localparam logic [7:0] OP_NORMAL     = 8'hA6;
   localparam logic [7:0] OP_INVERT     = 8'hA7;
   localparam logic [7:0] OP_DISPLAYON  = 8'hAF;

   localparam int FRAME_BYTES = 1024;
   localparam int CMD_BYTES   = 10;
   localparam int TOTAL_BYTES = FRAME_BYTES + CMD_BYTES;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_TAIL,
      ST_GUARD
   } seq_state_e;

   // Configuration burst: horizontal addressing, full column
   // and page window, normal/inverse, display on.
   function automatic logic [7:0] cmd_rom(
      input logic [3:0] idx,
      input logic       inv
   );
      logic [7:0] b;
      case (idx)
         4'd0:    b = OP_MEMORYMODE;
         4'd1:    b = 8'h00;
         4'd2:    b = OP_COLUMNADDR;
         4'd3:    b = 8'h00;
         4'd4:    b = 8'h7F;
         4'd5:    b = OP_PAGEADDR;
         4'd6:    b = 8'h00;
         4'd7:    b = 8'h07;
         4'd8:    b = inv ? OP_INVERT : OP_NORMAL;
         default: b = OP_DISPLAYON;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// SPI mode-0 byte shifter: one load pulse sends 8 bits MSB first.
// Ports: load_i/byte_i/dc_i in; done_o (last cycle of bit 0); scl_o/mosi_o/dc_o out.
module spi_byte_tx
   import ssd1306_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_i,
   input  logic [7:0] byte_i,
   input  logic       dc_i,
   output logic       done_o,
   output logic       scl_o,
   output logic       mosi_o,
   output logic       dc_o
);

   localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

   logic       active_q, active_d;
   logic       scl_q, scl_d;
   logic       mosi_q, mosi_d;
   logic       dc_q, dc_d;
   logic [6:0] sh_q, sh_d;
   logic [7:0] div_q, div_d;
   logic [2:0] bit_q, bit_d;
   logic       half_end;

   always_comb begin
      half_end = (div_q == HALF_LAST);
      done_o   = active_q & scl_q & half_end & (bit_q == 3'd0);
      active_d = active_q;
      scl_d    = scl_q;
      mosi_d   = mosi_q;
      dc_d     = dc_q;
      sh_d     = sh_q;
      div_d    = div_q;
      bit_d    = bit_q;
      if (load_i) begin
         active_d = 1'b1;
         scl_d    = 1'b0;
         mosi_d   = byte_i[7];
         sh_d     = byte_i[6:0];
         dc_d     = dc_i;
         div_d    = '0;
         bit_d    = 3'd7;
      end else if (active_q) begin
         if (half_end) begin
            div_d = '0;
            scl_d = ~scl_q;
            // Falling edge: present the next bit.
            if (scl_q) begin
               mosi_d = sh_q[6];
               sh_d   = {sh_q[5:0], 1'b0};
               if (bit_q == 3'd0) begin
                  active_d = 1'b0;
               end else begin
                  bit_d = bit_q - 3'd1;
               end
            end
         end else begin
            div_d = div_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         active_q <= 1'b0;
         scl_q    <= 1'b0;
         mosi_q   <= 1'b0;
         dc_q     <= 1'b0;
         sh_q     <= '0;
         div_q    <= '0;
         bit_q    <= '0;
      end else begin
         active_q <= active_d;
         scl_q    <= scl_d;
         mosi_q   <= mosi_d;
         dc_q     <= dc_d;
         sh_q     <= sh_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
      end
   end

   assign scl_o  = scl_q;
   assign mosi_o = mosi_q;
   assign dc_o   = dc_q;

endmodule

// File: rtl/ssd1306_frame_sequencer.sv
// Pushes one 128x64 frame (10 command + 1024 data bytes) into an SSD1306 over SPI.
// Ports: start_i/invert_i request; busy_o/done_o status; rd_addr_o/rd_data_i RAM; ss/scl/mosi/dc SPI.
module ssd1306_frame_sequencer
   import ssd1306_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       rst_i,
   input  logic       clk_i,
   input  logic       start_i,
   input  logic       invert_i,
   output logic       busy_o,
   output logic       done_o,
   output logic [9:0] rd_addr_o,
   input  logic [7:0] rd_data_i,
   output logic       ss_o,
   output logic       scl_o,
   output logic       mosi_o,
   output logic       dc_o
);

   localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [10:0] LAST_IDX = 11'(TOTAL_BYTES - 1);
   localparam logic [10:0] CMD_N    = 11'(CMD_BYTES);

   seq_state_e  state_q, state_d;
   logic [7:0]  gap_q, gap_d;
   logic [10:0] cnt_q, cnt_d;
   logic        pend_q, pend_d;
   logic        inv_q, inv_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        ss_q, ss_d;
   logic [9:0]  addr_q, addr_d;
   logic [7:0]  byte_q, byte_d;

   logic        tx_load;
   logic [7:0]  tx_byte;
   logic        tx_dc;
   logic        tx_done;
   logic        is_data;
   logic        gap_last;
   logic [10:0] nxt_cnt;

   spi_byte_tx #(
      .CLK_DIV (CLK_DIV)
   ) u_tx (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (tx_load),
      .byte_i (tx_byte),
      .dc_i   (tx_dc),
      .done_o (tx_done),
      .scl_o  (scl_o),
      .mosi_o (mosi_o),
      .dc_o   (dc_o)
   );

   always_comb begin
      state_d  = state_q;
      gap_d    = gap_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      inv_d    = inv_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      ss_d     = ss_q;
      addr_d   = addr_q;
      byte_d   = byte_q;
      tx_load  = 1'b0;
      nxt_cnt  = cnt_q + 11'd1;
      is_data  = (cnt_q >= CMD_N);
      gap_last = (gap_q == DIV_LAST);
      tx_dc    = is_data;
      // RAM data is valid on the second gap cycle; with CLK_DIV=2
      // that is also the load cycle, so bypass the capture register.
      if (is_data) begin
         tx_byte = (gap_q == 8'd1) ? rd_data_i : byte_q;
      end else begin
         tx_byte = cmd_rom(cnt_q[3:0], inv_q);
      end
      if (state_q != ST_IDLE && start_i) begin
         pend_d = 1'b1;
      end
      unique case (state_q)
         ST_IDLE: begin
            if (start_i || pend_q) begin
               state_d = ST_LOAD;
               pend_d  = 1'b0;
               inv_d   = invert_i;
               busy_d  = 1'b1;
               ss_d    = 1'b0;
               cnt_d   = '0;
               gap_d   = '0;
            end
         end
         ST_LOAD: begin
            gap_d = gap_q + 8'd1;
            if (gap_q == 8'd1) begin
               byte_d = rd_data_i;
            end
            if (gap_last) begin
               tx_load = 1'b1;
               gap_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (tx_done) begin
               if (cnt_q < LAST_IDX) begin
                  cnt_d   = nxt_cnt;
                  state_d = ST_LOAD;
                  if (nxt_cnt >= CMD_N) begin
                     addr_d = 10'(nxt_cnt - CMD_N);
                  end
               end else begin
                  state_d = ST_TAIL;
               end
            end
         end
         ST_TAIL: begin
            gap_d = gap_q + 8'd1;
            if (gap_last) begin
               gap_d   = '0;
               ss_d    = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_GUARD;
            end
         end
         ST_GUARD: begin
            gap_d = gap_q + 8'd1;
            if (gap_last) begin
               gap_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         gap_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         inv_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ss_q    <= 1'b1;
         addr_q  <= '0;
         byte_q  <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         inv_q   <= inv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ss_q    <= ss_d;
         addr_q  <= addr_d;
         byte_q  <= byte_d;
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign ss_o      = ss_q;
   assign rd_addr_o = addr_q;

endmodule

// File: tb/tb_ssd1306_frame_sequencer.sv
// Bench for ssd1306_frame_sequencer: SPI decoder, RAM model, byte-table checks.
// Covers reset, full frame, invert latch, pending restart, async reset mid-frame.
module tb_ssd1306_frame_sequencer;

   localparam int CD    = 2;
   localparam int BYTEP = 17 * CD;
   localparam int FRAME = 1034 * BYTEP + CD;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       invert;
   logic       busy_o, done_o, ss_o, scl_o, mosi_o, dc_o;
   logic [9:0] rd_addr_o;
   logic [7:0] rd_data;
   logic [7:0] mem [1024];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int proto_err = 0;
   int per_err = 0;
   int done_cnt = 0;
   logic [8:0] rxq [$];

   typedef struct packed {
      logic [10:0] idx;
      logic [8:0]  e1;
      logic [8:0]  e0;
   } vec_t;
   vec_t vecs [16];

   ssd1306_frame_sequencer #(
      .CLK_DIV (CD)
   ) dut (
      .rst_i     (rst),
      .clk_i     (clk),
      .start_i   (start),
      .invert_i  (invert),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .rd_addr_o (rd_addr_o),
      .rd_data_i (rd_data),
      .ss_o      (ss_o),
      .scl_o     (scl_o),
      .mosi_o    (mosi_o),
      .dc_o      (dc_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) rd_data <= mem[rd_addr_o];

   // SPI decoder and protocol monitor.
   int         bitn = 0;
   int         last_rise = -1;
   logic [7:0] shreg = 8'd0;
   logic       byte_dc = 1'b0;
   logic       scl_p = 1'b0;
   logic       mosi_p = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         bitn = 0;
         last_rise = -1;
      end else begin
         if (busy_o && ss_o) proto_err++;
         if (done_o) done_cnt++;
         if (ss_o) begin
            bitn = 0;
            last_rise = -1;
         end
         if (scl_o && scl_p && mosi_o !== mosi_p) proto_err++;
         if (!ss_o && bitn != 0 && dc_o !== byte_dc) proto_err++;
         if (!ss_o && scl_o && !scl_p) begin
            if (bitn == 0) begin
               byte_dc = dc_o;
               if (last_rise >= 0 && cyc - last_rise != BYTEP) per_err++;
               last_rise = cyc;
            end
            shreg = {shreg[6:0], mosi_o};
            bitn++;
            if (bitn == 8) begin
               rxq.push_back({byte_dc, shreg});
               bitn = 0;
            end
         end
      end
      scl_p  = scl_o;
      mosi_p = mosi_o;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] outs();
      return {ss_o, scl_o, mosi_o, dc_o, busy_o, done_o, rd_addr_o};
   endfunction

   function automatic logic [8:0] model(input int i, input bit inv);
      logic [7:0] c [10];
      c = '{8'h20, 8'h00, 8'h21, 8'h00, 8'h7F,
            8'h22, 8'h00, 8'h07, 8'hA6, 8'hAF};
      if (i < 10) begin
         if (i == 8 && inv) return {1'b0, 8'hA7};
         return {1'b0, c[i]};
      end
      return {1'b1, 8'((i - 10) % 256)};
   endfunction

   task automatic wait_bytes(input int n, input string nm);
      int k = 0;
      while (rxq.size() < n && k < 40000) begin
         @(negedge clk);
         k++;
      end
      chk(nm, 64'(rxq.size() >= n), 64'd1);
   endtask

   task automatic check_vecs(input int base, input int lim, input bit inv, input string tag);
      for (int v = 0; v < 16; v++) begin
         int i;
         i = int'(vecs[v].idx);
         if (i < lim) begin
            chk($sformatf("%s_byte%0d", tag, i), 64'(rxq[base + i]),
                64'(inv ? vecs[v].e1 : vecs[v].e0));
         end
      end
   endtask

   task automatic check_stream(input int base, input int n, input bit inv, input string nm);
      int mism = 0;
      for (int i = 0; i < n; i++) begin
         if (rxq[base + i] !== model(i, inv)) mism++;
      end
      chk(nm, 64'(mism), 64'd0);
   endtask

   initial begin
      int t_acc, t_done, k, b2, b3;
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
      vecs[0]  = '{11'd0,    9'h020, 9'h020};
      vecs[1]  = '{11'd1,    9'h000, 9'h000};
      vecs[2]  = '{11'd2,    9'h021, 9'h021};
      vecs[3]  = '{11'd3,    9'h000, 9'h000};
      vecs[4]  = '{11'd4,    9'h07F, 9'h07F};
      vecs[5]  = '{11'd5,    9'h022, 9'h022};
      vecs[6]  = '{11'd6,    9'h000, 9'h000};
      vecs[7]  = '{11'd7,    9'h007, 9'h007};
      vecs[8]  = '{11'd8,    9'h0A7, 9'h0A6};
      vecs[9]  = '{11'd9,    9'h0AF, 9'h0AF};
      vecs[10] = '{11'd10,   9'h100, 9'h100};
      vecs[11] = '{11'd11,   9'h101, 9'h101};
      vecs[12] = '{11'd265,  9'h1FF, 9'h1FF};
      vecs[13] = '{11'd266,  9'h100, 9'h100};
      vecs[14] = '{11'd509,  9'h1F3, 9'h1F3};
      vecs[15] = '{11'd1033, 9'h1FF, 9'h1FF};

      rst = 1'b1;
      start = 1'b0;
      invert = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_state", 64'(outs()), 64'h8000);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_state", 64'(outs()), 64'h8000);

      // Frame 1: inverted, invert toggled and start pulsed mid-frame.
      invert = 1'b1;
      start = 1'b1;
      @(negedge clk);
      t_acc = cyc;
      start = 1'b0;
      chk("accept_busy_ss", 64'({busy_o, ss_o}), 64'b10);
      k = 0;
      while (!scl_o && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("first_scl_rise", 64'(cyc - t_acc), 64'(2 * CD));
      wait_bytes(20, "wait_b20");
      invert = 1'b0;
      wait_bytes(100, "wait_b100");
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_bytes(200, "wait_b200");
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_bytes(300, "wait_b300");
      start = 1'b1; @(negedge clk); start = 1'b0;
      k = 0;
      while (!done_o && k < 40000) begin
         @(negedge clk);
         k++;
      end
      t_done = cyc;
      chk("frame_latency", 64'(t_done - t_acc), 64'(FRAME));
      chk("busy_at_done", 64'(busy_o), 64'd0);
      chk("frame1_bytes", 64'(rxq.size()), 64'd1034);
      b2 = rxq.size();
      @(negedge clk);
      chk("done_width", 64'(done_o), 64'd0);
      k = 0;
      while (ss_o && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("pending_restart", 64'(cyc - t_done), 64'(CD + 1));
      chk("done_count1", 64'(done_cnt), 64'd1);
      check_vecs(0, 1034, 1'b1, "f1");
      check_stream(0, 1034, 1'b1, "f1_stream");

      // Frame 2: pending request, then reset during data byte 500.
      wait_bytes(b2 + 50, "wait_f2_b50");
      start = 1'b1; @(negedge clk); start = 1'b0;
      k = 0;
      while (rd_addr_o != 10'd500 && k < 30000) begin
         @(negedge clk);
         k++;
      end
      chk("reach_addr500", 64'(rd_addr_o), 64'd500);
      repeat (10) @(negedge clk);
      #1 rst = 1'b1;
      #1 chk("async_reset", 64'(outs()), 64'h8000);
      repeat (3) @(negedge clk);
      chk("f2_bytes", 64'(rxq.size() - b2), 64'd510);
      check_vecs(b2, 510, 1'b0, "f2");
      check_stream(b2, 510, 1'b0, "f2_stream");
      rst = 1'b0;
      repeat (100) @(negedge clk);
      chk("no_done_on_reset", 64'(done_cnt), 64'd1);
      chk("pending_cleared", 64'({ss_o, busy_o}), 64'b10);

      // Frame 3: normal start after reset.
      b3 = rxq.size();
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_bytes(b3 + 40, "wait_f3_b40");
      check_vecs(b3, 40, 1'b0, "f3");
      check_stream(b3, 40, 1'b0, "f3_stream");

      chk("protocol", 64'(proto_err), 64'd0);
      chk("byte_period", 64'(per_err), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ssd1306_frame_sequencer.md
# ssd1306_frame_sequencer

Master-side controller that pushes one full 128x64 frame into the SSD1306 display core over its 4-wire SPI (ss/scl/mosi/dc) input. On a start request it emits a fixed configuration command burst, then streams 1024 framebuffer bytes fetched from a synchronous source RAM, then releases the bus. It sits between the game-side framebuffer and the display core. It is the only driver of the core's SPI pins.

## Interface
- CLK_DIV, 4: SCL half-period in clk_i cycles; legal range 2..255.
- rst_i  in  1  asynchronous, active-high reset
- clk_i  in  1  system clock; all logic on its rising edge
- start_i  in  1  frame request, sampled every cycle
- invert_i  in  1  sampled on frame acceptance; selects A7 (1) or A6 (0) in the command burst
- busy_o  out  1  high from acceptance until the cycle done_o pulses, exclusive
- done_o  out  1  one-cycle pulse when ss_o returns high
- rd_addr_o  out  10  framebuffer byte index = {page[2:0], col[6:0]}
- rd_data_i  in  8  framebuffer byte; valid exactly 1 cycle after rd_addr_o is presented
- ss_o  out  1  slave select, active low
- scl_o  out  1  SPI clock, idle low (mode 0)
- mosi_o  out  1  serial data, MSB first
- dc_o  out  1  0 = command byte, 1 = data byte

## Operation
- Reset values: ss_o=1, scl_o=0, mosi_o=0, dc_o=0, busy_o=0, done_o=0, rd_addr_o=0, pending=0, FSM=IDLE.
- Byte stream per frame, 1034 bytes total:
  - Commands, dc=0: 20 00, 21 00 7F, 22 00 07, A6|invert, AF.
  - Then 1024 data bytes, dc=1, rd_addr 0..1023 ascending.
- FSM states:
  - IDLE: start_i or pending -> LOAD. Clears pending, latches invert_i, asserts busy_o, drives ss_o=0.
  - LOAD: gap of CLK_DIV cycles with scl_o=0.
    - Command byte: taken from the 10-entry command ROM by index.
    - Data byte: rd_addr_o is presented on the first gap cycle and rd_data_i is captured on the second.
    - dc_o and mosi_o (bit 7) are updated on the last gap cycle.
    - Next state: SHIFT.
  - SHIFT: 8 bits, each 2*CLK_DIV cycles.
    - scl_o is low for the first CLK_DIV cycles of the bit, high for the next CLK_DIV.
    - mosi_o changes only on scl falling, or at the last LOAD cycle for bit 7.
    - After bit 0, scl_o is low: byte index < 1033 -> LOAD; otherwise -> TAIL.
  - TAIL: CLK_DIV cycles with scl_o=0 and ss_o=0, then ss_o=1, done_o=1, busy_o=0 -> GUARD.
  - GUARD: CLK_DIV cycles with ss_o=1 (minimum deselect time) -> IDLE.
- start_i while busy_o or in GUARD sets pending. Multiple requests merge into one pending frame, and the next frame starts on the first IDLE cycle. start_i in IDLE is accepted immediately.
- dc_o is held stable through all 8 bits of a byte. It changes only in LOAD.
- Byte counter is 11 bits, 0..1033. Data address = counter − 10, truncated to 10 bits. There is no wrap within a frame.
- Reset mid-frame: all outputs return to reset values asynchronously, so the slave sees ss rise and discards the partial byte. pending is cleared. No done_o pulse.

## Timing
- Acceptance edge: busy_o=1 and ss_o=0 in the next cycle. The first scl rise comes 2*CLK_DIV cycles after ss_o falls.
- Per byte: 17*CLK_DIV cycles (gap CLK_DIV + 16*CLK_DIV shift).
- Frame, start to done_o: 1034*17*CLK_DIV + CLK_DIV cycles. With CLK_DIV=4 this is 70316 cycles.
- Read latency: rd_data_i is registered exactly 1 cycle after rd_addr_o changes. CLK_DIV≥2 guarantees capture before the mosi load.

## Structure
- Package ssd1306_pkg:
  - opcode constants (MEMORYMODE 20, COLUMNADDR 21, PAGEADDR 22, NORMAL A6, INVERT A7, DISPLAYON AF);
  - FSM state enum;
  - FRAME_BYTES=1024 and CMD_BYTES=10.
- Sub-module spi_byte_tx (parameter CLK_DIV):
  - holds the shift register, half-period counter and bit counter;
  - load/byte/dc in, done out;
  - drives scl_o, mosi_o and dc_o.
- The top level holds the FSM, command ROM, byte counter, pending flag and RAM read port.

## Test plan
- Reset, then a single start_i with invert_i=0 and the RAM model filled with addr[7:0]. A bench SPI decoder must capture bytes 20 00 21 00 7F 22 00 07 A6 AF with dc=0, then 00..FF repeated 4 times with dc=1. done_o pulses once, 70316 cycles after acceptance (CLK_DIV=4).
- invert_i=1 at acceptance, then toggled mid-frame -> the 9th byte is A7 and the rest of the stream is unchanged.
- Protocol checks: mosi stable while scl high, dc constant within each byte, ss low for the entire frame. Repeat with CLK_DIV=2 and CLK_DIV=7 and check byte period = 17*CLK_DIV.
- start_i pulsed 3 times during a frame -> exactly one extra frame, whose ss_o falls CLK_DIV+1 cycles after the first done_o.
- rst_i asserted during data byte 500 -> same cycle ss_o=1, scl_o=0, busy_o=0, with no done_o pulse. A following start_i produces a complete, correct frame.
